// File: rtl/w21_col_mac_seq.sv
// Purpose: walks a combinational weight ROM, multiplies each weight by one streamed activation, accumulates a signed dot product.
// Latency: DEPTH+2 cycles from accepted start to res_valid with no activation stalls; product-to-accumulate is one cycle.
// Backpressure: act_ready stalls are unlimited; res_valid/res_data hold until res_ready. Optional saturation: W21_MAC_SAT_EN.
module w21_col_mac_seq #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 21,
    parameter int DEPTH  = 300,
    parameter int ACT_W  = 8,
    parameter int ACC_W  = 38,
    parameter int OUT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    input  logic              act_valid,
    output logic              act_ready,
    input  logic [ACT_W-1:0]  act_data,
    output logic [ADDR_W-1:0] adrs_clm,
    input  logic [DATA_W-1:0] rom_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_data,
    output logic              done
);

    localparam int PROD_W = DATA_W + ACT_W;
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t                    state;
    logic signed [PROD_W-1:0]  p_reg;
    logic                      p_vld;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DATA_W-1:0]  w_s;
    logic signed [ACT_W-1:0]   a_s;
    logic signed [PROD_W-1:0]  prod;
    logic                      beat;

    assign w_s  = rom_data;
    assign a_s  = act_data;
    assign prod = w_s * a_s;
    assign beat = act_valid & act_ready;

    // Control FSM: address walk, handshakes and all registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            act_ready <= 1'b0;
            adrs_clm  <= '0;
            res_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        adrs_clm  <= '0;
                        act_ready <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (beat) begin
                        if (adrs_clm == LAST_ADR) begin
                            // Final pair taken: hold the address and stop accepting.
                            act_ready <= 1'b0;
                            state     <= DRAIN;
                        end else begin
                            adrs_clm <= adrs_clm + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // The last product is being added this cycle; result is ready next.
                    res_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage datapath: register the full-precision product, then accumulate it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg <= '0;
            p_vld <= 1'b0;
            acc   <= '0;
        end else begin
            p_vld <= beat;
            if (beat) begin
                p_reg <= prod;
            end
            if (state == IDLE && start) begin
                acc <= '0;
            end else if (p_vld) begin
                acc <= acc + {{(ACC_W-PROD_W){p_reg[PROD_W-1]}}, p_reg};
            end
        end
    end

    // Reduce the accumulator to the output width.
    always_comb begin
        res_data = acc[OUT_W-1:0];
`ifdef W21_MAC_SAT_EN
        if (acc > OUT_MAX) begin
            res_data = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (acc < OUT_MIN) begin
            res_data = {1'b1, {(OUT_W-1){1'b0}}};
        end
`endif
    end

endmodule

// File: tb/tb_w21_col_mac_seq.sv
module tb_w21_col_mac_seq;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 21;
    localparam int DEPTH  = 300;
    localparam int ACT_W  = 8;
    localparam int ACC_W  = 38;
    localparam int OUT_W  = 32;
    localparam int BOUND  = 3000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              act_valid = 1'b0;
    logic              act_ready;
    logic [ACT_W-1:0]  act_data = '0;
    logic [ADDR_W-1:0] adrs_clm;
    logic [DATA_W-1:0] rom_data;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [OUT_W-1:0]  res_data;
    logic              done;

    int vectors = 0;
    int miscompares = 0;

    int wt [512];
    int acts [DEPTH];

    always #5 clk = ~clk;

    // ROM model: combinational lookup from the column address.
    always_comb rom_data = DATA_W'(wt[adrs_clm]);

    w21_col_mac_seq #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .ACT_W(ACT_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .adrs_clm(adrs_clm), .rom_data(rom_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .done(done)
    );

    // Reference: plain dot product over the table, then width reduction.
    function automatic longint ref_acc();
        longint s = 0;
        for (int i = 0; i < DEPTH; i++) s += longint'(wt[i]) * longint'(acts[i]);
        return s;
    endfunction

    function automatic logic [OUT_W-1:0] ref_res(input longint a);
        logic [63:0] v;
        v = a;
`ifdef W21_MAC_SAT_EN
        if (a > 64'sd2147483647) return 32'h7fffffff;
        if (a < -64'sd2147483648) return 32'h80000000;
`endif
        return v[OUT_W-1:0];
    endfunction

    function automatic int rnd_w();
        return int'($urandom_range(0, (1 << DATA_W) - 1)) - (1 << (DATA_W - 1));
    endfunction

    function automatic int rnd_a();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // Drives one run up to the first res_valid (or an abort); reports observations only.
    task automatic drive_run(input int pct, input bit inj_start, input int abort_at,
                             output int cycles, output int adr_err, output int done_seen,
                             output bit timed_out, output bit aborted);
        int beats = 0;
        bit v, rdy;
        int n = 0;
        int expa;
        cycles = -1; adr_err = 0; done_seen = 0; timed_out = 1'b0; aborted = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (1) begin
            @(negedge clk);
            n++;
            if (done) done_seen++;
            expa = (beats < DEPTH) ? beats : DEPTH - 1;
            if (int'(adrs_clm) != expa || int'(adrs_clm) >= DEPTH) adr_err++;
            if (res_valid) begin
                cycles = n;
                act_valid = 1'b0;
                break;
            end
            if (n > BOUND) begin
                timed_out = 1'b1;
                act_valid = 1'b0;
                break;
            end
            if (abort_at >= 0 && beats == abort_at) begin
                rst_n = 1'b0;
                act_valid = 1'b0;
                #1 aborted = 1'b1;
                break;
            end
            rdy = act_ready;
            v = ($urandom_range(99) < pct);
            act_valid = v;
            act_data = (beats < DEPTH) ? ACT_W'(acts[beats]) : '0;
            if (inj_start && n == 50) start = 1'b1;
            @(posedge clk);
            #1;
            if (v && rdy) beats++;
            start = 1'b0;
        end
    endtask

    // Holds res_ready low for 'hold' cycles, then completes the handshake; reports observations.
    task automatic handshake(input int hold, input bit inj_start, output logic [OUT_W-1:0] got,
                             output int unstable, output int done_early, output int done_cnt,
                             output logic done_first, output int busy_after, output int vld_after);
        got = res_data;
        unstable = 0; done_early = 0; done_cnt = 0; busy_after = 0; vld_after = 0;
        done_first = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (res_valid !== 1'b1 || res_data !== got) unstable++;
            if (done) done_early++;
            if (inj_start && i == 5) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
        end
        if (res_valid !== 1'b1 || res_data !== got) unstable++;
        res_ready = 1'b1;
        start = inj_start;
        @(posedge clk);
        #1 res_ready = 1'b0;
        start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (j == 0) done_first = done;
            if (done) done_cnt++;
            if (busy) busy_after++;
            if (res_valid) vld_after++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if ({busy, act_ready, res_valid, done} !== 4'b0) begin miscompares++;
            $display("FAIL reset_ctrl: got %b want 0000", {busy, act_ready, res_valid, done}); end
        vectors++; if (adrs_clm !== '0) begin miscompares++;
            $display("FAIL reset_adrs: got %0d want 0", adrs_clm); end
        vectors++; if (res_data !== '0) begin miscompares++;
            $display("FAIL reset_res: got %0d want 0", res_data); end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if ({busy, act_ready, res_valid, done} !== 4'b0) begin miscompares++;
            $display("FAIL idle_after_reset: got %b want 0000", {busy, act_ready, res_valid, done}); end
    endtask

    task automatic test_sparse();
        int cyc, ae, ds, un, de, dc, ba, va; bit to, ab; logic df; logic [OUT_W-1:0] got;
        for (int i = 0; i < DEPTH; i++) begin wt[i] = rnd_w(); acts[i] = 0; end
        wt[0] = -139; wt[1] = 383; acts[0] = 1; acts[1] = 1;
        drive_run(100, 1'b0, -1, cyc, ae, ds, to, ab);
        vectors++; if (to) begin miscompares++; $display("FAIL sparse_timeout: no res_valid within %0d cycles", BOUND); end
        handshake(0, 1'b0, got, un, de, dc, df, ba, va);
        vectors++; if (got !== 32'd244) begin miscompares++; $display("FAIL sparse_res: got %0d want 244", $signed(got)); end
        vectors++; if (dc != 1 || df !== 1'b1) begin miscompares++; $display("FAIL sparse_done: got %0d pulses first=%b want 1 first=1", dc, df); end
        vectors++; if (ba != 0 || busy !== 1'b0) begin miscompares++; $display("FAIL sparse_busy: got %0d busy cycles want 0", ba); end
    endtask

    task automatic test_ramp(input int pct);
        int cyc, ae, ds, un, de, dc, ba, va; bit to, ab; logic df; logic [OUT_W-1:0] got;
        for (int i = 0; i < DEPTH; i++) begin wt[i] = i; acts[i] = 1; end
        drive_run(pct, 1'b0, -1, cyc, ae, ds, to, ab);
        vectors++; if (to) begin miscompares++; $display("FAIL ramp_timeout: pct %0d no res_valid", pct); end
        if (pct == 100) begin
            vectors++; if (cyc != DEPTH + 2) begin miscompares++; $display("FAIL ramp_latency: got %0d want %0d", cyc, DEPTH + 2); end
        end
        vectors++; if (ae != 0) begin miscompares++; $display("FAIL ramp_adrs: pct %0d got %0d address errors want 0", pct, ae); end
        handshake(0, 1'b0, got, un, de, dc, df, ba, va);
        vectors++; if (got !== 32'd44850) begin miscompares++; $display("FAIL ramp_res: pct %0d got %0d want 44850", pct, $signed(got)); end
        vectors++; if (va != 0 || dc != 1) begin miscompares++; $display("FAIL ramp_hs: got vld_after=%0d done=%0d want 0 1", va, dc); end
    endtask

    task automatic test_extreme();
        int cyc, ae, ds, un, de, dc, ba, va; bit to, ab; logic df; logic [OUT_W-1:0] got, want;
        for (int i = 0; i < DEPTH; i++) begin wt[i] = -1048576; acts[i] = -128; end
`ifdef W21_MAC_SAT_EN
        want = 32'd2147483647;
`else
        want = 32'd1610612736;
`endif
        vectors++; if (ref_res(ref_acc()) !== want || ref_acc() != 64'd40265318400) begin miscompares++;
            $display("FAIL extreme_model: got %0d want %0d", ref_res(ref_acc()), want); end
        drive_run(100, 1'b0, -1, cyc, ae, ds, to, ab);
        handshake(2, 1'b0, got, un, de, dc, df, ba, va);
        vectors++; if (to || got !== want) begin miscompares++; $display("FAIL extreme_res: got %0d want %0d", got, want); end
    endtask

    task automatic test_backpressure(input int hold, input int pct);
        int cyc, ae, ds, un, de, dc, ba, va; bit to, ab; logic df; logic [OUT_W-1:0] got, want;
        for (int i = 0; i < DEPTH; i++) begin wt[i] = rnd_w(); acts[i] = rnd_a(); end
        want = ref_res(ref_acc());
        drive_run(pct, 1'b1, -1, cyc, ae, ds, to, ab);
        vectors++; if (to || ae != 0) begin miscompares++; $display("FAIL bp_run: timeout=%0d adrs_err=%0d want 0 0", to, ae); end
        handshake(hold, 1'b1, got, un, de, dc, df, ba, va);
        vectors++; if (got !== want) begin miscompares++; $display("FAIL bp_res: got %0d want %0d", $signed(got), $signed(want)); end
        vectors++; if (un != 0) begin miscompares++; $display("FAIL bp_stable: got %0d unstable cycles want 0", un); end
        vectors++; if (de != 0 || ds != 0 || dc != 1 || df !== 1'b1) begin miscompares++;
            $display("FAIL bp_done: early=%0d run=%0d after=%0d first=%b want 0 0 1 1", de, ds, dc, df); end
        vectors++; if (ba != 0) begin miscompares++; $display("FAIL bp_start_ignored: got busy %0d cycles want 0", ba); end
    endtask

    task automatic test_abort();
        int cyc, ae, ds; bit to, ab;
        for (int i = 0; i < DEPTH; i++) begin wt[i] = i; acts[i] = 1; end
        drive_run(100, 1'b0, 150, cyc, ae, ds, to, ab);
        vectors++; if (!ab || ds != 0) begin miscompares++; $display("FAIL abort_reach: aborted=%0d done=%0d want 1 0", ab, ds); end
        vectors++; if ({busy, act_ready, res_valid, done} !== 4'b0 || adrs_clm !== '0) begin miscompares++;
            $display("FAIL abort_state: ctrl=%b adrs=%0d want 0000 0", {busy, act_ready, res_valid, done}, adrs_clm); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_ramp(100);
    endtask

    task automatic test_random_runs();
        int cyc, ae, ds, un, de, dc, ba, va; bit to, ab; logic df; logic [OUT_W-1:0] got, want;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < DEPTH; i++) begin wt[i] = rnd_w(); acts[i] = rnd_a(); end
            if (r == 3) for (int i = 0; i < DEPTH; i++) begin wt[i] = 1048575; acts[i] = -128; end
            want = ref_res(ref_acc());
            drive_run(int'($urandom_range(30, 100)), 1'b0, -1, cyc, ae, ds, to, ab);
            handshake(int'($urandom_range(0, 6)), 1'b0, got, un, de, dc, df, ba, va);
            vectors++; if (to || got !== want || un != 0) begin miscompares++;
                $display("FAIL rand_run%0d: got %0d want %0d unstable=%0d", r, $signed(got), $signed(want), un); end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) wt[i] = 0;
        test_reset();
        test_sparse();
        test_ramp(100);
        test_ramp(50);
        test_extreme();
        test_backpressure(20, 70);
        test_abort();
        test_random_runs();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
